// File: rtl/bounce_emulator_pkg.sv
// Shared types and constants for the bounce emulator and its LFSR.
package bounce_emulator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/bounce_emulator_lfsr16.sv
// Free-running 16-bit Galois LFSR (mask LFSR_POLY); reset loads seed, advances every cycle.
// Output is the register itself (no combinational path); no backpressure.
module lfsr16
    import bounce_emulator_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_POLY : 16'h0000);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bounce_emulator.sv
// Turns a level request into a bouncing contact signal; edges appear one cycle after start, done is a 1-cycle pulse.
// start is ignored outside IDLE (no backpressure); optional settle glitch under BOUNCE_EMULATOR_GLITCH_EN.
module bounce_emulator
    import bounce_emulator_pkg::*;
#(
    parameter int          BOUNCE_PAIRS  = 3,
    parameter int          MIN_DWELL     = 16,
    parameter int          DWELL_RAND_W  = 6,
    parameter int          SETTLE_CYCLES = 2_000_000,
    parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic target_level,
    output logic noisy_out,
    output logic busy,
    output logic done
);

    localparam int DW = $clog2(MIN_DWELL + 2**DWELL_RAND_W);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(2*BOUNCE_PAIRS + 2);

    localparam logic [TW-1:0] TOGGLES_INIT = TW'(2*BOUNCE_PAIRS);
    localparam logic [SW-1:0] SETTLE_INIT  = SW'(SETTLE_CYCLES);

    state_t          state_q,  state_d;
    logic            noisy_q,  noisy_d;
    logic            tgt_q,    tgt_d;
    logic [DW-1:0]   dwell_q,  dwell_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [TW-1:0]   tog_q,    tog_d;
    logic [15:0]     lfsr;
    logic [DW-1:0]   dwell_new;
    logic            unused_lfsr_bits;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (LFSR_SEED),
        .q       (lfsr)
    );

    // Upper LFSR bits only feed the optional glitch path.
    assign unused_lfsr_bits = ^lfsr;
    assign dwell_new        = DW'(MIN_DWELL) + DW'(lfsr[DWELL_RAND_W-1:0]);

    always_comb begin
        state_d  = state_q;
        noisy_d  = noisy_q;
        tgt_d    = tgt_q;
        dwell_d  = dwell_q;
        settle_d = settle_q;
        tog_d    = tog_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (target_level != noisy_q) begin
                        tgt_d   = target_level;
                        noisy_d = ~noisy_q;
                        dwell_d = dwell_new;
                        tog_d   = TOGGLES_INIT;
                        if (BOUNCE_PAIRS == 0) begin
                            state_d  = SETTLE;
                            settle_d = SETTLE_INIT;
                        end else begin
                            state_d = BOUNCE;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BOUNCE: begin
                if (dwell_q == DW'(1)) begin
                    noisy_d = ~noisy_q;
                    dwell_d = dwell_new;
                    tog_d   = tog_q - TW'(1);
                    if (tog_q == TW'(1)) begin
                        // Final edge lands on the latched target (matches odd-toggle parity).
                        noisy_d  = tgt_q;
                        state_d  = SETTLE;
                        settle_d = SETTLE_INIT;
                    end
                end else begin
                    dwell_d = dwell_q - DW'(1);
                end
            end
            SETTLE: begin
                if (settle_q == SW'(1)) begin
                    state_d = DONE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            noisy_q  <= 1'b0;
            tgt_q    <= 1'b0;
            dwell_q  <= '0;
            settle_q <= '0;
            tog_q    <= '0;
        end else begin
            state_q  <= state_d;
            noisy_q  <= noisy_d;
            tgt_q    <= tgt_d;
            dwell_q  <= dwell_d;
            settle_q <= settle_d;
            tog_q    <= tog_d;
        end
    end

    assign busy = (state_q == BOUNCE) || (state_q == SETTLE);
    assign done = (state_q == DONE);

`ifdef BOUNCE_EMULATOR_GLITCH_EN
    // Glitch is armed with >=5 cycles left so it is visible with >=4 left, clear of the last 3.
    localparam int GLITCH_MIN_LEFT = 5;

    logic glitch_q,      glitch_d;
    logic glitch_used_q, glitch_used_d;

    always_comb begin
        glitch_d      = 1'b0;
        glitch_used_d = (state_q == SETTLE) ? glitch_used_q : 1'b0;
        if ((state_q == SETTLE) && !glitch_used_q && (lfsr[7:0] == 8'h00) &&
            (32'(settle_q) >= 32'(GLITCH_MIN_LEFT))) begin
            glitch_d      = 1'b1;
            glitch_used_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_q      <= 1'b0;
            glitch_used_q <= 1'b0;
        end else begin
            glitch_q      <= glitch_d;
            glitch_used_q <= glitch_used_d;
        end
    end

    assign noisy_out = noisy_q ^ glitch_q;
`else
    assign noisy_out = noisy_q;
`endif

endmodule

// File: tb/tb_bounce_emulator.sv
// Randomized scoreboard bench for bounce_emulator: driver queues expected transactions, monitor checks them on done.
module tb_bounce_emulator;

    localparam int BP    = 2;
    localparam int MIN_D = 4;
    localparam int RW    = 2;
    localparam int SC    = 10;
    localparam int NTOG  = 2*BP + 1;
    localparam int MAX_D = MIN_D + (1 << RW) - 1;

    logic clk          = 1'b0;
    logic reset_n      = 1'b0;
    logic start        = 1'b0;
    logic target_level = 1'b0;
    logic noisy_out;
    logic busy;
    logic done;

    bounce_emulator #(
        .BOUNCE_PAIRS  (BP),
        .MIN_DWELL     (MIN_D),
        .DWELL_RAND_W  (RW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .target_level (target_level),
        .noisy_out    (noisy_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   t_start;
        int   exp_tog;
        logic tgt;
    } exp_t;

    exp_t sb[$];
    int   tog_t[$];
    int   checks   = 0;
    int   errors   = 0;
    int   busy_bad = 0;
    logic model_level = 1'b0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_noisy = 1'b0;
    logic exp_busy;
    exp_t mon_e;
    int   bad;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_noisy = 1'b0;
            tog_t.delete();
            busy_bad   = 0;
        end else begin
            if (noisy_out !== prev_noisy) begin
                if (sb.size() == 0 || cyc <= sb[0].t_start)
                    check_eq("toggle_outside_request", 1, 0);
                else
                    tog_t.push_back(cyc);
                prev_noisy = noisy_out;
            end
            exp_busy = (sb.size() > 0) && (cyc > sb[0].t_start) && (sb[0].exp_tog > 0) && !done;
            if (busy !== exp_busy) busy_bad++;
            if (done) begin
                if (sb.size() == 0) begin
                    check_eq("done_without_request", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("toggle_count", tog_t.size(), mon_e.exp_tog);
                    check_eq("final_level", int'(noisy_out), int'(mon_e.tgt));
                    check_eq("busy_profile_errs", busy_bad, 0);
                    if (mon_e.exp_tog == 0) begin
                        check_eq("done_latency_no_edge", cyc, mon_e.t_start + 1);
                    end else if (tog_t.size() > 0) begin
                        check_eq("first_toggle_cycle", tog_t[0], mon_e.t_start + 1);
                        bad = 0;
                        for (int i = 1; i < tog_t.size(); i++) begin
                            if (tog_t[i] - tog_t[i-1] < MIN_D || tog_t[i] - tog_t[i-1] > MAX_D)
                                bad++;
                        end
                        check_eq("dwell_out_of_range", bad, 0);
                        check_eq("settle_len", cyc - tog_t[tog_t.size()-1], SC);
                    end
                end
                tog_t.delete();
                busy_bad = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) tick();
    endtask

    task automatic issue(input logic tgt);
        exp_t e;
        e.t_start = cyc;
        e.tgt     = tgt;
        e.exp_tog = (tgt != model_level) ? NTOG : 0;
        sb.push_back(e);
        model_level  = tgt;
        start        = 1'b1;
        target_level = tgt;
    endtask

    task automatic wait_done(input bit spam);
        int n = 0;
        tick();
        while (!done && n < 500) begin
            start        = spam ? 1'($urandom) : 1'b0;
            target_level = 1'($urandom);
            tick();
            n++;
        end
        if (!done) begin
            check_eq("done_timeout", 0, 1);
            sb.delete();
        end
        // A start in the done cycle that would cause an edge if it were accepted.
        start        = 1'b1;
        target_level = ~model_level;
        tick();
        start = 1'b0;
    endtask

    task automatic reset_pulse();
        #1 reset_n = 1'b0;
        #1 check_eq("reset_async_outputs", int'({noisy_out, busy, done}), 0);
        sb.delete();
        model_level = 1'b0;
        start       = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic repro_run(output int first_ofs, output int d1, output int d2);
        int   tt[$];
        int   t;
        int   n;
        logic pv;
        reset_pulse();
        idle(7);
        t = cyc;
        issue(1'b1);
        pv = noisy_out;
        tick();
        start = 1'b0;
        n = 0;
        while (tt.size() < 3 && n < 40) begin
            if (noisy_out !== pv) begin
                tt.push_back(cyc);
                pv = noisy_out;
            end
            tick();
            n++;
        end
        if (tt.size() < 3) begin
            first_ofs = -1; d1 = -1; d2 = -1;
        end else begin
            first_ofs = tt[0] - t;
            d1 = tt[1] - tt[0];
            d2 = tt[2] - tt[1];
        end
        check_eq("mid_bounce_busy", int'(busy), 1);
    endtask

    int idle_bad;
    int fa, a1, a2, fb, b1, b2;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        idle_bad = 0;
        repeat (50) begin
            tick();
            if (noisy_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
        end
        check_eq("idle_after_reset", idle_bad, 0);

        issue(1'b0); wait_done(1'b0);
        issue(1'b1); wait_done(1'b0);
        issue(1'b1); wait_done(1'b1);
        issue(1'b0); wait_done(1'b1);
        issue(1'b1); wait_done(1'b1);

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            issue(1'($urandom));
            wait_done(1'($urandom));
        end

        repro_run(fa, a1, a2);
        repro_run(fb, b1, b2);
        check_eq("repro_first_ofs_a", fa, 1);
        check_eq("repro_first_ofs_b", fb, 1);
        check_eq("repro_dwell_range", int'(a1 >= MIN_D && a1 <= MAX_D && a2 >= MIN_D && a2 <= MAX_D), 1);
        check_eq("repro_dwell1", b1, a1);
        check_eq("repro_dwell2", b2, a2);
        reset_pulse();

        idle(3);
        issue(1'b1); wait_done(1'b1);
        issue(1'b0); wait_done(1'b0);

        idle(5);
        check_eq("busy_profile_tail", busy_bad, 0);
        check_eq("pending_at_end", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
